pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the 5-stage RV32I pipeline core.
- Sits between ID and EX. Keeps a scoreboard of in-flight destination registers for every stage after ID.
- Drives stall and flush controls for the PC, IF/ID and ID/EX registers, and selects forwarded operands for EX.
- Replaces the current free-running pipeline, which has no interlock, with correct RAW and control-hazard handling.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.
- DEPTH, 3, number of scoreboard stages after ID (EX, MEM, WB...); legal range 2..4.
- LOAD_LAT, 1, number of leading stages in which load data is not yet available; legal range 1..DEPTH-1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_use1, id_use2  in  1  the instruction actually reads rs1 / rs2
- id_rd  in  REG_AW  ID destination register
- id_wen  in  1  ID instruction writes rd
- id_load  in  1  ID instruction is a load
- ex_redirect  in  1  EX resolved a taken branch or a jal
- rf_rdata1, rf_rdata2  in  XLEN  register file read data
- stg_data  in  DEPTH*XLEN  final result of each stage; slice k is stage k, k=0 is EX
- stall_pc, stall_ifid  out  1  hold the PC / IF-ID register
- flush_ifid, flush_idex  out  1  load a bubble into IF-ID / ID-EX
- fwd_sel1, fwd_sel2  out  3  0 = register file, k+1 = stage k
- op1, op2  out  XLEN  forwarded operands, registered into ID/EX
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Scoreboard: DEPTH entries {v, rd, wen, load}. Entry 0 is EX. On every clk edge entry k shifts to k+1 and entry DEPTH-1 is dropped.
- Entry 0 load value:
  - ID fields when id_valid and neither stall nor flush_idex is asserted.
  - Otherwise v=0.
- An entry matches source s when all hold: v=1, wen=1, rd!=0, rd==s, and the matching use bit is set.
- Load-use stall (comb): any entry k<LOAD_LAT with load=1 matches rs1 or rs2 while id_valid=1.
  - stall_pc=stall_ifid=1, flush_idex=1.
  - The stall repeats each cycle until the load passes stage LOAD_LAT-1. With LOAD_LAT=1 that is exactly 1 bubble.
- Redirect (comb):
  - ex_redirect=1 forces flush_ifid=1, flush_idex=1, stall_pc=0, stall_ifid=0.
  - Redirect overrides a simultaneous load-use stall.
  - Total penalty is 2 squashed instructions.
- Forwarding (comb):
  - fwd_selN = 1 + the lowest-index matching entry; 0 if no entry matches.
  - Youngest producer wins.
  - rd=0 never forwards.
  - opN = the selected stg_data slice, or rf_rdataN.
  - While stalled, fwd_sel is don't-care because flush_idex discards the result.
- Reset:
  - While rst=1: all scoreboard v=0, counters=0, stall_pc=stall_ifid=0, flush_ifid=flush_idex=1, fwd_sel=0.
  - Outputs are valid from the first edge after rst falls.
  - Reset mid-stall aborts the stall immediately.
- Counters:
  - stall_cnt increments on each cycle with a load-use stall.
  - flush_cnt increments once per cycle with ex_redirect=1.
  - Both saturate at all-ones; they never wrap.
- No internal latency beyond the scoreboard register. All control outputs are combinational from inputs and scoreboard state.

Optional Feature:
- HAZ_PERF_CNT_EN.
  - Defined: stall_cnt and flush_cnt are implemented as above.
  - Undefined: no counter flops; both outputs are tied to 0. Ports remain present.

Test Plan:
- ALU RAW: addi x5,x0,7 followed by add x6,x5,x5 → no stall; fwd_sel1=fwd_sel2=1; op1=op2=7 from the EX slice.
- Load-use: lw x5 (mem value 0x1234) followed by add x6,x5,x0 → exactly 1 cycle of stall_pc=stall_ifid=flush_idex=1, then fwd_sel1=2, op1=0x1234, stall_cnt=1.
- Priority: EX writes x3=9, MEM writes x3=4, ID reads x3 → fwd_sel1=1, op1=9. With EX not writing → fwd_sel1=2, op1=4.
- x0 and unused sources: producer rd=x0 with result 0xFFFF, consumer reads x0 → fwd_sel=0, op=rf_rdata. Matching rs2 with id_use2=0 → no stall.
- Redirect during load-use: ex_redirect=1 in the same cycle as a load-use match → flush_ifid=flush_idex=1, stall_pc=0, flush_cnt+1, stall_cnt unchanged.
- Reset mid-stall: assert rst during a load-use stall → next cycle scoreboard is empty, counters=0, stall outputs 0. With DEPTH=4, LOAD_LAT=2 → a dependent instruction right after a load stalls 2 cycles.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: RAW interlock, operand forwarding and control-hazard flush
// controller for the 5-stage RV32I pipeline. Sits between ID and EX.
// Optional feature macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
module pipe_hazard_unit #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_wen,
    input  logic                  id_load,
    input  logic                  ex_redirect,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic [DEPTH*XLEN-1:0] stg_data,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic [2:0]            fwd_sel1,
    output logic [2:0]            fwd_sel2,
    output logic [XLEN-1:0]       op1,
    output logic [XLEN-1:0]       op2,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Scoreboard of in-flight instructions; entry 0 is EX. The load flag only
    // matters while data is unavailable, so it is kept for LOAD_LAT entries.
    logic [DEPTH-1:0]             sb_v;
    logic [DEPTH-1:0]             sb_wen;
    logic [DEPTH-1:0][REG_AW-1:0] sb_rd;
    logic [LOAD_LAT-1:0]          sb_load;

    logic [DEPTH-1:0] hit1, hit2;
    logic             load_use;

    // Per-entry source match; x0 and unused sources never match
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit1[k] = sb_v[k] && sb_wen[k] && (sb_rd[k] != '0) && (sb_rd[k] == id_rs1) && id_use1;
            hit2[k] = sb_v[k] && sb_wen[k] && (sb_rd[k] != '0) && (sb_rd[k] == id_rs2) && id_use2;
        end
    end

    // Load-use hazard: a load whose data is not yet available feeds ID
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++)
            if (sb_load[k] && (hit1[k] || hit2[k])) load_use = 1'b1;
        load_use = load_use && id_valid;
    end

    // Pipeline controls; redirect beats the stall, reset forces bubbles
    always_comb begin
        stall_pc   = !rst && load_use && !ex_redirect;
        stall_ifid = stall_pc;
        flush_ifid = rst || ex_redirect;
        flush_idex = rst || ex_redirect || load_use;
    end

    // Forward select: youngest (lowest-index) matching producer wins
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (hit1[k]) fwd_sel1 = 3'(k + 1);
            if (hit2[k]) fwd_sel2 = 3'(k + 1);
        end
        if (rst) begin
            fwd_sel1 = '0;
            fwd_sel2 = '0;
        end
    end

    // Operand mux: register file or the selected stage result
    always_comb begin
        op1 = rf_rdata1;
        op2 = rf_rdata2;
        for (int k = 0; k < DEPTH; k++) begin
            if (fwd_sel1 == 3'(k + 1)) op1 = stg_data[k*XLEN +: XLEN];
            if (fwd_sel2 == 3'(k + 1)) op2 = stg_data[k*XLEN +: XLEN];
        end
    end

    // Scoreboard shift; a stalled or flushed ID enters EX as a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v    <= '0;
            sb_wen  <= '0;
            sb_rd   <= '0;
            sb_load <= '0;
        end else begin
            for (int k = DEPTH-1; k >= 1; k--) begin
                sb_v[k]   <= sb_v[k-1];
                sb_wen[k] <= sb_wen[k-1];
                sb_rd[k]  <= sb_rd[k-1];
            end
            for (int k = LOAD_LAT-1; k >= 1; k--)
                sb_load[k] <= sb_load[k-1];
            sb_v[0]    <= id_valid && !flush_idex;
            sb_wen[0]  <= id_wen;
            sb_rd[0]   <= id_rd;
            sb_load[0] <= id_load;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating performance counters; a redirected cycle is not a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (ex_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
